// File: rtl/spike_mux_pkg.sv
// Shared definitions for the replay-buffer mux and the spike demux:
// the window-phase encoding, default sizes, and the spike-time width helper.
package spike_mux_pkg;

    // Owner of the current gamma window
    typedef enum logic {
        PH_NET1 = 1'b0,
        PH_NET2 = 1'b1
    } phase_t;

    localparam int unsigned Q_DEF         = 2;
    localparam int unsigned GAMMA_LEN_DEF = 16;

    // Width of a spike-time value for a window of gamma_len cycles
    function automatic int unsigned time_width(input int unsigned gamma_len);
        return (gamma_len < 2) ? 1 : $clog2(gamma_len);
    endfunction

endpackage

// File: rtl/spike_demux_if.sv
// Column-side bus of the spike demux.
//   grst           : first cycle of each gamma window (one-cycle pulse)
//   col_spikes     : shared column output spikes
//   output_spikes1 : network-1 replayed spikes
//   output_spikes2 : network-2 replayed spikes
//   frame_done     : pulse after a frame moves to the replay bank
//   phase          : current window owner
interface spike_demux_if
    import spike_mux_pkg::*;
#(
    parameter int unsigned Q = Q_DEF
);
    logic         grst;
    logic [Q-1:0] col_spikes;
    logic [Q-1:0] output_spikes1;
    logic [Q-1:0] output_spikes2;
    logic         frame_done;
    phase_t       phase;

    modport master (
        output grst,
        output col_spikes,
        input  output_spikes1,
        input  output_spikes2,
        input  frame_done,
        input  phase
    );

    modport slave (
        input  grst,
        input  col_spikes,
        output output_spikes1,
        output output_spikes2,
        output frame_done,
        output phase
    );
endinterface

// File: rtl/spike_demux_lane.sv
// One neuron's capture/replay storage.
//   t_now     : effective window time of this cycle
//   phase_now : effective window owner of this cycle
//   transfer  : capture bank moves to the replay bank this cycle
//   spike     : this neuron's column spike
//   match_c   : per-network replay hit this cycle (bit 0 = net 1, bit 1 = net 2)
module demux_lane
    import spike_mux_pkg::*;
#(
    parameter int unsigned TW = 4
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic [TW-1:0] t_now,
    input  phase_t        phase_now,
    input  logic          transfer,
    input  logic          spike,
    output logic [1:0]    match_c
);

    logic [1:0]    cap_v, cap_v_nxt;
    logic [1:0]    rep_v, rep_v_nxt;
    logic [TW-1:0] cap_t     [2];
    logic [TW-1:0] cap_t_nxt [2];
    logic [TW-1:0] rep_t     [2];
    logic [TW-1:0] rep_t_src [2];
    logic [1:0]    rep_v_src;
    logic          p;

    // Replay source bypasses the capture bank on a transfer so time-0 hits survive
    always_comb begin
        p            = logic'(phase_now);
        rep_v_src    = transfer ? cap_v : rep_v;
        rep_t_src[0] = transfer ? cap_t[0] : rep_t[0];
        rep_t_src[1] = transfer ? cap_t[1] : rep_t[1];
        for (int n = 0; n < 2; n++) begin
            match_c[n] = (phase_now == PH_NET1) && rep_v_src[n] && (rep_t_src[n] == t_now);
        end
        // A matched entry is consumed so it pulses once even at a saturated count
        rep_v_nxt = rep_v_src & ~match_c;
    end

    // First spike per window wins; a transfer starts from a cleared bank
    always_comb begin
        cap_v_nxt    = transfer ? 2'b00 : cap_v;
        cap_t_nxt[0] = transfer ? '0 : cap_t[0];
        cap_t_nxt[1] = transfer ? '0 : cap_t[1];
        if (spike && !cap_v_nxt[p]) begin
            cap_v_nxt[p] = 1'b1;
            cap_t_nxt[p] = t_now;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cap_v    <= 2'b00;
            rep_v    <= 2'b00;
            cap_t[0] <= '0;
            cap_t[1] <= '0;
            rep_t[0] <= '0;
            rep_t[1] <= '0;
        end else begin
            cap_v    <= cap_v_nxt;
            rep_v    <= rep_v_nxt;
            cap_t[0] <= cap_t_nxt[0];
            cap_t[1] <= cap_t_nxt[1];
            rep_t[0] <= rep_t_src[0];
            rep_t[1] <= rep_t_src[1];
        end
    end

endmodule

// File: rtl/spike_demux.sv
// Splits the time-shared column output into per-network spike trains:
// captures first-spike times per window, replays both networks aligned
// during window 0 of the following frame.
//   clk  : clock
//   rstb : asynchronous active-low reset
//   bus  : column-side bus (grst, col_spikes in; replayed spikes, frame_done, phase out)
module spike_demux
    import spike_mux_pkg::*;
#(
    parameter int unsigned Q         = Q_DEF,
    parameter int unsigned GAMMA_LEN = GAMMA_LEN_DEF
) (
    input  logic          clk,
    input  logic          rstb,
    spike_demux_if.slave  bus
);

    localparam int unsigned   TW    = time_width(GAMMA_LEN);
    localparam logic [TW-1:0] T_MAX = TW'(GAMMA_LEN - 1);

    logic [TW-1:0] cnt, cnt_nxt, t_now;
    phase_t        phase_q, phase_now;
    logic          transfer_c;
    logic [1:0]    match_c [Q];
    logic [Q-1:0]  sp1_c, sp2_c;
    logic [Q-1:0]  sp1_q, sp2_q;
    logic          frame_done_q;

    // A grst cycle is cycle 0 of the next window; the counter saturates if grst is late
    always_comb begin
        t_now      = bus.grst ? '0 : cnt;
        phase_now  = bus.grst ? phase_t'(~phase_q) : phase_q;
        transfer_c = bus.grst && (phase_q == PH_NET2);
        cnt_nxt    = (t_now == T_MAX) ? T_MAX : t_now + TW'(1);
    end

    for (genvar g = 0; g < Q; g++) begin : g_lane
        demux_lane #(.TW(TW)) u_lane (
            .clk       (clk),
            .rstb      (rstb),
            .t_now     (t_now),
            .phase_now (phase_now),
            .transfer  (transfer_c),
            .spike     (bus.col_spikes[g]),
            .match_c   (match_c[g])
        );
    end

    always_comb begin
        sp1_c = '0;
        sp2_c = '0;
        for (int q = 0; q < Q; q++) begin
            sp1_c[q] = match_c[q][0];
            sp2_c[q] = match_c[q][1];
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt          <= '0;
            phase_q      <= PH_NET2;
            frame_done_q <= 1'b0;
            sp1_q        <= '0;
            sp2_q        <= '0;
        end else begin
            cnt          <= cnt_nxt;
            phase_q      <= phase_now;
            frame_done_q <= transfer_c;
            sp1_q        <= sp1_c;
            sp2_q        <= sp2_c;
        end
    end

    assign bus.output_spikes1 = sp1_q;
    assign bus.output_spikes2 = sp2_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.phase          = phase_q;

endmodule

// File: tb/tb_spike_demux.sv
// Directed bench for spike_demux (Q=2, GAMMA_LEN=16). Each window is driven
// with grst on its first cycle; outputs are recorded by the cycle in which
// they are visible (index c = window cycle c) and checked against hand-derived values.
module tb_spike_demux;

    logic clk;
    logic rstb;

    spike_demux_if #(.Q(2)) bus ();

    spike_demux #(.Q(2), .GAMMA_LEN(16)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_bad;

    logic [1:0] stim [64];
    logic [1:0] o1   [66];
    logic [1:0] o2   [66];
    logic       fd   [66];
    logic       ph   [66];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one window of len cycles from stim[], record visible outputs
    task automatic run_window(input int len);
        for (int i = 0; i < 66; i++) begin
            o1[i] = '0; o2[i] = '0; fd[i] = 1'b0; ph[i] = 1'b0;
        end
        for (int i = 0; i < len; i++) begin
            bus.grst       = (i == 0);
            bus.col_spikes = stim[i];
            @(posedge clk);
            #1;
            o1[i+1] = bus.output_spikes1;
            o2[i+1] = bus.output_spikes2;
            fd[i+1] = bus.frame_done;
            ph[i+1] = bus.phase;
        end
        bus.grst       = 1'b0;
        bus.col_spikes = '0;
        for (int i = 0; i < 64; i++) stim[i] = '0;
    endtask

    function automatic int npulse(input int net, input int q, input int len);
        int c = 0;
        for (int i = 1; i <= len; i++) c += int'(net == 1 ? o1[i][q] : o2[i][q]);
        return c;
    endfunction

    function automatic int first_at(input int net, input int q, input int len);
        for (int i = 1; i <= len; i++)
            if ((net == 1 ? o1[i][q] : o2[i][q]) == 1'b1) return i;
        return -1;
    endfunction

    function automatic int nfd(input int len);
        int c = 0;
        for (int i = 1; i <= len; i++) c += int'(fd[i]);
        return c;
    endfunction

    function automatic int nall(input int len);
        return npulse(1, 0, len) + npulse(1, 1, len) + npulse(2, 0, len) + npulse(2, 1, len);
    endfunction

    initial begin
        n_chk = 0;
        n_bad = 0;
        rstb           = 1'b0;
        bus.grst       = 1'b0;
        bus.col_spikes = '0;
        for (int i = 0; i < 64; i++) stim[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out1",  int'(bus.output_spikes1), 0);
        check_eq("rst_out2",  int'(bus.output_spikes2), 0);
        check_eq("rst_fd",    int'(bus.frame_done), 0);
        check_eq("rst_phase", int'(bus.phase), 1);
        rstb = 1'b1;
        @(posedge clk);
        #1;

        // Idle frame: first grst after reset transfers an empty bank
        run_window(16);
        check_eq("idle_ph0",    int'(ph[1]), 0);
        check_eq("idle_fd1",    int'(fd[1]), 1);
        check_eq("idle_fdcnt0", nfd(16), 1);
        check_eq("idle_out0",   nall(16), 0);
        run_window(16);
        check_eq("idle_ph1",    int'(ph[1]), 1);
        check_eq("idle_fdcnt1", nfd(16), 0);
        check_eq("idle_out1",   nall(16), 0);

        // n0 at t=3 in phase 0, n1 at t=7 in phase 1
        stim[3] = 2'b01;
        run_window(16);
        stim[7] = 2'b10;
        run_window(16);
        // Replay frame; also n0 spikes at 2,5,9 (first only)
        stim[2] = 2'b01; stim[5] = 2'b01; stim[9] = 2'b01;
        run_window(16);
        check_eq("rep_ph",     int'(ph[1]), 0);
        check_eq("rep_fd",     int'(fd[1]), 1);
        check_eq("rep1_n0_at", first_at(1, 0, 16), 4);
        check_eq("rep1_n0_n",  npulse(1, 0, 16), 1);
        check_eq("rep2_n1_at", first_at(2, 1, 16), 8);
        check_eq("rep2_n1_n",  npulse(2, 1, 16), 1);
        check_eq("rep_other",  npulse(1, 1, 16) + npulse(2, 0, 16), 0);
        run_window(16);
        check_eq("ph1_quiet",  nall(16), 0);

        // First-spike-only replay; n1 spike coincident with the transfer grst
        stim[0] = 2'b10;
        run_window(16);
        check_eq("first_at",   first_at(1, 0, 16), 3);
        check_eq("first_n",    npulse(1, 0, 16), 1);
        check_eq("coinc_now",  npulse(1, 1, 16), 0);
        check_eq("first_net2", npulse(2, 0, 16) + npulse(2, 1, 16), 0);

        // Late grst in phase 1: n1 at cycles 20, 30 clamps to time 15
        stim[20] = 2'b10; stim[30] = 2'b10;
        run_window(40);
        check_eq("late_ph", int'(ph[1]), 1);
        run_window(20);
        check_eq("coinc_at",   first_at(1, 1, 20), 1);
        check_eq("coinc_n",    npulse(1, 1, 20), 1);
        check_eq("clamp_at",   first_at(2, 1, 20), 16);
        check_eq("clamp_n",    npulse(2, 1, 20), 1);
        check_eq("clamp_rest", npulse(1, 0, 20) + npulse(2, 0, 20), 0);

        // Mid-operation reset with a pulse showing and a replay still pending
        stim[2] = 2'b01; stim[10] = 2'b10;
        run_window(16);
        run_window(3);
        check_eq("pre_rst_pulse", int'(o2[3]), 1);
        rstb = 1'b0;
        #1;
        check_eq("rst_mid_out2",  int'(bus.output_spikes2), 0);
        check_eq("rst_mid_out1",  int'(bus.output_spikes1), 0);
        check_eq("rst_mid_phase", int'(bus.phase), 1);
        @(posedge clk);
        #1;
        rstb = 1'b1;
        run_window(16);
        check_eq("post_ph0",  int'(ph[1]), 0);
        check_eq("post_fd",   int'(fd[1]), 1);
        check_eq("post_out0", nall(16), 0);
        run_window(16);
        run_window(16);
        check_eq("post_out2", nall(16), 0);

        // Back-to-back grst: windows of length 1
        run_window(1);
        check_eq("b2b_ph1", int'(ph[1]), 1);
        check_eq("b2b_fd1", int'(fd[1]), 0);
        run_window(1);
        check_eq("b2b_ph0", int'(ph[1]), 0);
        check_eq("b2b_fd0", int'(fd[1]), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
